// File: rtl/sram_tester_mc.sv
// rtl/sram_tester_mc.sv - multi-chip SRAM write/verify sweep engine with pattern select
// Optional SRAM_TESTER_STOP_ON_ERR_EN: halt in a terminal STOP state on the first mismatch.
module sram_tester_mc #(
    parameter int ADDR_WIDTH = 21,
    parameter int CS_BITS    = 2,
    parameter int DATA_WIDTH = 8,
    parameter int ERR_WIDTH  = 16,
    parameter int LED_DIV    = 22
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [1:0]                 mode,
    inout  wire  [DATA_WIDTH-1:0]      sram_dq,
    output logic [ADDR_WIDTH-CS_BITS-1:0] sram_addr,
    output logic [(1<<CS_BITS)-1:0]    sram_cs_n,
    output logic                       sram_we_n,
    output logic                       sram_oe_n,
    output logic                       busy,
    output logic [15:0]                pass_count,
    output logic [ERR_WIDTH-1:0]       err_count,
    output logic [ADDR_WIDTH-1:0]      fail_addr,
    output logic                       led
);
    localparam int NCHIPS = 1 << CS_BITS;
    localparam int IN_W = ADDR_WIDTH - CS_BITS;
    localparam logic [31:0] LFSR_MASK = 32'h80200003;
    localparam logic [15:0] SEED_HI = 16'hACE1;

    typedef enum logic [2:0] {
        S_IDLE, S_WRITE, S_TURN, S_READ, S_END
`ifdef SRAM_TESTER_STOP_ON_ERR_EN
        , S_STOP
`endif
    } state_t;

    state_t state, state_next;
    logic [1:0] phase;
    logic [ADDR_WIDTH-1:0] addr;
    logic [31:0] lfsr, lfsr_next;
    logic [1:0] mode_q;
    logic sticky, pass_err, led_q, sel, dq_en, last_phase, last_addr, mismatch;
    logic [LED_DIV:0] led_cnt;
    logic [DATA_WIDTH-1:0] pattern;
    logic [CS_BITS-1:0] chip;

    assign last_phase = (phase == 2'd2);
    assign last_addr  = &addr;
    assign lfsr_next  = {1'b0, lfsr[31:1]} ^ (lfsr[0] ? LFSR_MASK : 32'h0);
    assign chip       = addr[ADDR_WIDTH-1 -: CS_BITS];
    assign sram_addr  = addr[IN_W-1:0];
    assign sram_cs_n  = ~(NCHIPS'(sel) << chip);
    assign sram_dq    = dq_en ? pattern : {DATA_WIDTH{1'bz}};
    assign mismatch   = (state == S_READ) && last_phase && (sram_dq != pattern);
    assign led        = sticky ? led_cnt[LED_DIV] : led_q;

    always_comb begin
        case (mode_q)
            2'd0:    pattern = lfsr[DATA_WIDTH-1:0];
            2'd1:    pattern = DATA_WIDTH'(addr) ^ DATA_WIDTH'(pass_count);
            2'd2:    pattern = DATA_WIDTH'(1) << ((32'(addr) + 32'(pass_count)) % 32'(DATA_WIDTH));
            default: pattern = ~lfsr[DATA_WIDTH-1:0];
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        sel        = 1'b0;
        dq_en      = 1'b0;
        sram_we_n  = 1'b1;
        sram_oe_n  = 1'b1;
        busy       = 1'b1;
        case (state)
            S_IDLE: begin
                busy       = 1'b0;
                state_next = S_WRITE;
            end
            S_WRITE: begin
                sel       = 1'b1;
                dq_en     = 1'b1;
                sram_we_n = (phase != 2'd1);
                if (last_phase && last_addr) state_next = S_TURN;
            end
            S_TURN: state_next = S_READ;
            S_READ: begin
                sel       = 1'b1;
                sram_oe_n = 1'b0;
`ifdef SRAM_TESTER_STOP_ON_ERR_EN
                if (mismatch) state_next = S_STOP;
                else
`endif
                if (last_phase && last_addr) state_next = S_END;
            end
            S_END: state_next = S_WRITE;
`ifdef SRAM_TESTER_STOP_ON_ERR_EN
            S_STOP: busy = 1'b0;
`endif
            default: state_next = S_IDLE;
        endcase
    end

    // The seed is reloaded before each sweep so READ regenerates the WRITE sequence.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase      <= 2'd0;
            addr       <= '0;
            lfsr       <= '0;
            mode_q     <= 2'd0;
            pass_count <= 16'd0;
            err_count  <= '0;
            fail_addr  <= '0;
            sticky     <= 1'b0;
            pass_err   <= 1'b0;
            led_q      <= 1'b0;
            led_cnt    <= '0;
        end else begin
            led_cnt <= led_cnt + 1'b1;
            case (state)
                S_IDLE: begin
                    lfsr   <= {SEED_HI, pass_count};
                    mode_q <= mode;
                    addr   <= '0;
                    phase  <= 2'd0;
                end
                S_WRITE, S_READ: begin
                    phase <= last_phase ? 2'd0 : phase + 2'd1;
                    if (last_phase) begin
                        addr <= addr + 1'b1;
                        lfsr <= lfsr_next;
                    end
                    if (mismatch) begin
                        if (!(&err_count)) err_count <= err_count + 1'b1;
                        if (!sticky) fail_addr <= addr;
                        sticky   <= 1'b1;
                        pass_err <= 1'b1;
                    end
                end
                S_TURN: lfsr <= {SEED_HI, pass_count};
                S_END: begin
                    pass_count <= pass_count + 16'd1;
                    if (!pass_err) led_q <= ~led_q;
                    pass_err <= 1'b0;
                    lfsr     <= {SEED_HI, pass_count + 16'd1};
                    mode_q   <= mode;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_sram_tester_mc.sv
// tb/tb_sram_tester_mc.sv - bench for sram_tester_mc with behavioural SRAM and schedule model
module tb_sram_tester_mc;
    localparam int AW = 6, CSB = 1, DW = 8, EW = 4, LD = 3, PASS_LEN = 386;
    localparam int K_IDLE = 0, K_WR = 1, K_TURN = 2, K_RD = 3, K_END = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [1:0] mode = 2'd0;
    wire  [DW-1:0] sram_dq;
    logic [AW-CSB-1:0] sram_addr;
    logic [1:0] sram_cs_n;
    logic sram_we_n, sram_oe_n, busy, led;
    logic [15:0] pass_count;
    logic [EW-1:0] err_count;
    logic [AW-1:0] fail_addr;

    int checks = 0, errors = 0, fault = 0;
    logic [DW-1:0] mem [64];
    logic cs_act;
    logic [5:0] full_a;

    int n, m_pass, m_err, m_fail;
    logic [1:0] m_mode;
    bit m_sticky, m_pass_err, m_led, m_stop;

    always #5 clk = ~clk;

    sram_tester_mc #(.ADDR_WIDTH(AW), .CS_BITS(CSB), .DATA_WIDTH(DW), .ERR_WIDTH(EW), .LED_DIV(LD)) dut (
        .clk(clk), .rst_n(rst_n), .mode(mode), .sram_dq(sram_dq), .sram_addr(sram_addr),
        .sram_cs_n(sram_cs_n), .sram_we_n(sram_we_n), .sram_oe_n(sram_oe_n), .busy(busy),
        .pass_count(pass_count), .err_count(err_count), .fail_addr(fail_addr), .led(led)
    );

    function automatic logic [7:0] apply_fault(input int f, input logic [7:0] v, input logic [5:0] a);
        if (f == 1 && a == 6'h25) return v & 8'hDF;
        if (f == 2) return ~v;
        return v;
    endfunction

    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        return (s >> 1) ^ (s[0] ? 32'h80200003 : 32'h0);
    endfunction

    function automatic logic [7:0] pattern(input logic [1:0] md, input int a, input int p);
        logic [31:0] s;
        s = {16'hACE1, 16'(p)};
        for (int k = 0; k < a; k++) s = lfsr_step(s);
        case (md)
            2'd0:    return s[7:0];
            2'd1:    return 8'(a ^ p);
            2'd2:    return 8'(1 << ((a + p) % 8));
            default: return ~s[7:0];
        endcase
    endfunction

    // Where cycle nn (edges since reset release) falls in the IDLE/WRITE/TURN/READ/END schedule.
    function automatic void pos(input int nn, output int kind, output int a, output int ph);
        int r;
        kind = K_IDLE; a = 0; ph = 0;
        if (nn > 0) begin
            r = (nn - 1) % PASS_LEN;
            if (r < 192)       begin kind = K_WR; a = r / 3; ph = r % 3; end
            else if (r == 192) kind = K_TURN;
            else if (r < 385)  begin kind = K_RD; a = (r - 193) / 3; ph = (r - 193) % 3; end
            else               kind = K_END;
        end
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    assign cs_act  = (sram_cs_n != 2'b11);
    assign full_a  = {sram_cs_n == 2'b01, sram_addr};
    assign sram_dq = (cs_act && !sram_oe_n && sram_we_n) ? apply_fault(fault, mem[full_a], full_a) : 'z;

    always @(posedge clk) if (cs_act && !sram_we_n) mem[full_a] <= sram_dq;

    initial begin
        int kind, a, ph;
        logic [7:0] exp;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                n = 0; m_pass = 0; m_err = 0; m_fail = 0; m_mode = 2'd0;
                m_sticky = 0; m_pass_err = 0; m_led = 0; m_stop = 0;
            end else begin
                pos(n, kind, a, ph);
                if (!m_stop) begin
                    if (kind == K_IDLE) m_mode = mode;
                    if (kind == K_RD && ph == 2) begin
                        exp = pattern(m_mode, a, m_pass);
                        if (apply_fault(fault, exp, 6'(a)) != exp) begin
                            if (m_err < 15) m_err++;
                            if (!m_sticky) m_fail = a;
                            m_sticky = 1; m_pass_err = 1;
`ifdef SRAM_TESTER_STOP_ON_ERR_EN
                            m_stop = 1;
`endif
                        end
                    end
                    if (kind == K_END) begin
                        m_pass = (m_pass + 1) % 65536;
                        if (!m_pass_err) m_led = !m_led;
                        m_pass_err = 0;
                        m_mode = mode;
                    end
                end
                n++;
            end
        end
    end

    initial begin
        int kind, a, ph;
        bit act;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                pos(n, kind, a, ph);
                act = !m_stop && (kind == K_WR || kind == K_RD);
                check("busy", busy, !m_stop && kind != K_IDLE);
                check("cs_n", sram_cs_n, act ? (a < 32 ? 2'b10 : 2'b01) : 2'b11);
                check("we_n", sram_we_n, !(act && kind == K_WR && ph == 1));
                check("oe_n", sram_oe_n, !(act && kind == K_RD));
                if (act) check("sram_addr", sram_addr, 32'(a % 32));
                if (act && kind == K_WR) check("wdata", sram_dq, pattern(m_mode, a, m_pass));
                check("pass_count", pass_count, 32'(m_pass));
                check("err_count", err_count, 32'(m_err));
                check("fail_addr", fail_addr, 32'(m_fail));
                check("led", led, m_sticky ? ((n >> LD) & 1) : m_led);
            end
        end
    end

    task automatic wait_pass(input int target, output int c);
        c = 0;
        while (pass_count != 16'(target) && c < 2000) begin
            @(negedge clk);
            c++;
        end
        check("pass_reached", pass_count, 32'(target));
    endtask

    task automatic restart(input int f, input logic [1:0] md);
        @(negedge clk);
        rst_n = 1'b0;
        fault = f;
        mode = md;
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;
    endtask

    initial begin
        int c;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_pass", pass_count, 0);
        check("rst_err", err_count, 0);
        check("rst_fail", fail_addr, 0);
        check("rst_led", led, 0);
        check("rst_we_n", sram_we_n, 1);
        check("rst_oe_n", sram_oe_n, 1);
        check("rst_cs_n", sram_cs_n, 2'b11);
        check("rst_addr", sram_addr, 0);
        check("pin_lfsr_a", lfsr_step(32'hACE10001), 32'hD6508003);
        check("pin_lfsr_b", lfsr_step(32'hACE10000), 32'h56708000);
        check("pin_axor", pattern(2'd1, 37, 0), 8'h25);
        check("pin_walk0", pattern(2'd2, 37, 0), 8'h20);
        check("pin_walk1", pattern(2'd2, 37, 1), 8'h40);
        check("pin_axor2", pattern(2'd1, 3, 2), 8'h01);

        // Clean run; mode switched mid-pass 0 only applies from pass 1.
        #1 rst_n = 1'b1;
        repeat (50) @(negedge clk);
        mode = 2'd3;
        wait_pass(1, c);
        check("first_pass_len", c + 50, 387);
        check("led_after_1", led, 1);
        wait_pass(2, c);
        check("second_pass_len", c, 386);
        check("led_after_2", led, 0);
        check("err_clean", err_count, 0);

        // Stuck dq[5] at 0x25 with walking-one.
        restart(1, 2'd2);
`ifndef SRAM_TESTER_STOP_ON_ERR_EN
        wait_pass(1, c);
        check("stuck_err_p0", err_count, 1);
        check("stuck_fail", fail_addr, 6'h25);
        wait_pass(2, c);
        check("stuck_err_p1", err_count, 1);
`else
        repeat (300) @(negedge clk);
        repeat (1000) @(negedge clk);
        check("stop_err", err_count, 1);
        check("stop_fail", fail_addr, 6'h25);
        check("stop_busy", busy, 0);
        check("stop_cs_n", sram_cs_n, 2'b11);
        check("stop_oe_n", sram_oe_n, 1);
        check("stop_we_n", sram_we_n, 1);
        check("stop_pass", pass_count, 0);
`endif

        // Every read inverted, address-XOR.
        restart(2, 2'd1);
`ifndef SRAM_TESTER_STOP_ON_ERR_EN
        wait_pass(1, c);
        check("sat_err", err_count, 15);
        check("sat_fail", fail_addr, 0);
`else
        repeat (400) @(negedge clk);
        check("stop_inv_err", err_count, 1);
`endif

        // Asynchronous reset in the middle of the write at 0x11.
        restart(0, 2'd0);
        c = 0;
        while (!(sram_we_n == 1'b0 && sram_addr == 5'h11 && sram_cs_n == 2'b10) && c < 500) begin
            @(negedge clk);
            c++;
        end
        check("reach_0x11", sram_addr, 5'h11);
        #2 rst_n = 1'b0;
        #1;
        check("async_we_n", sram_we_n, 1);
        check("async_oe_n", sram_oe_n, 1);
        check("async_cs_n", sram_cs_n, 2'b11);
        check("async_addr", sram_addr, 0);
        check("async_busy", busy, 0);
        check("async_pass", pass_count, 0);
        @(negedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("restart_addr", sram_addr, 0);
        check("restart_cs_n", sram_cs_n, 2'b10);
        check("restart_pass", pass_count, 0);
        repeat (100) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
